occ_gtp_link_ctrl: RTL and testbench

//  Sequences bring-up of one occ_gtpe2_tile: PLL reset, lock wait, TX/RX PCS reset, comma alignment.

---
 rtl/occ_gtp_ctrl_pkg.sv | 25 ++
 rtl/occ_gtp_sync_bit.sv | 24 ++
 rtl/occ_gtp_link_ctrl.sv | 185 ++++++++++++++++++
 tb/tb_occ_gtp_link_ctrl.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/occ_gtp_ctrl_pkg.sv
// Shared definitions for the GTP link bring-up controller: state encoding,
// fixed sequencing lengths and a small helper for sizing the shared timer.
package occ_gtp_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_PLL_RST  = 3'd1,
    ST_PLL_WAIT = 3'd2,
    ST_GT_RST   = 3'd3,
    ST_GT_WAIT  = 3'd4,
    ST_ALIGN    = 3'd5,
    ST_LINK_UP  = 3'd6
  } state_e;

  localparam int C_LOCK_STABLE   = 8;  // consecutive locked cycles before PCS reset
  localparam int C_GT_RST_CYCLES = 4;  // txreset/rxreset pulse length
  localparam int C_SYNC_STAGES   = 2;  // synchroniser depth for tile status inputs

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/occ_gtp_sync_bit.sv
// Multi-flop synchroniser for one asynchronous status bit coming from the tile.
module occ_gtp_sync_bit
  import occ_gtp_ctrl_pkg::*;
(
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);

  logic [C_SYNC_STAGES-1:0] sync_q;

  // Shift the asynchronous level through the synchroniser chain.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[C_SYNC_STAGES-2:0], d_i};
    end
  end

  assign q_o = sync_q[C_SYNC_STAGES-1];

endmodule

// File: rtl/occ_gtp_link_ctrl.sv
// Bring-up sequencer and supervisor for one GTP tile: PLL reset, lock wait,
// PCS reset, comma alignment, then link supervision with automatic retry.
module occ_gtp_link_ctrl
  import occ_gtp_ctrl_pkg::*;
#(
  parameter int g_PLL_RST_CYCLES = 200,
  parameter int g_TIMEOUT        = 65535,
  parameter int g_ERR_WINDOW     = 4096,
  parameter int g_ERR_MAX        = 16
) (
  input  logic       init_clk_i,
  input  logic       init_rst_i,
  input  logic       enable_i,
  input  logic       pll_lock_i,
  input  logic       txresetdone_i,
  input  logic       rxresetdone_i,
  input  logic       rx_aligned_i,
  input  logic       link_err_i,
  output logic       pll_rst_o,
  output logic       txreset_o,
  output logic       rxreset_o,
  output logic       txuserrdy_o,
  output logic       rxuserrdy_o,
  output logic       rxencommaalign_o,
  output logic       link_up_o,
  output logic [2:0] state_o,
  output logic [7:0] retry_cnt_o
);

  localparam int TW = $clog2(max3(g_TIMEOUT, g_ERR_WINDOW, g_PLL_RST_CYCLES) + 1);
  localparam int EW = $clog2(g_ERR_MAX + 1);
  localparam int LW = $clog2(C_LOCK_STABLE);

  // Timer values seen on the last cycle of each timed phase.
  localparam logic [TW-1:0] C_PLL_LAST  = TW'(g_PLL_RST_CYCLES - 1);
  localparam logic [TW-1:0] C_TO_LAST   = TW'(g_TIMEOUT - 1);
  localparam logic [TW-1:0] C_WIN_LAST  = TW'(g_ERR_WINDOW - 1);
  localparam logic [TW-1:0] C_GT_LAST   = TW'(C_GT_RST_CYCLES - 1);
  localparam logic [LW-1:0] C_LOCK_LAST = LW'(C_LOCK_STABLE - 1);
  localparam logic [EW-1:0] C_ERR_LAST  = EW'(g_ERR_MAX - 1);
  localparam logic [EW-1:0] C_ERR_SAT   = EW'(g_ERR_MAX);

  logic lock_s, txdone_s, rxdone_s, aligned_s;

  state_e        state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [LW-1:0] lock_cnt_q, lock_cnt_d;
  logic [EW-1:0] err_cnt_q, err_cnt_d;
  logic [7:0]    retry_q, retry_d;
  logic          pll_rst_q, pll_rst_d;
  logic          gt_rst_q, gt_rst_d;
  logic          userrdy_q, userrdy_d;
  logic          comma_q, comma_d;
  logic          link_up_q, link_up_d;
  logic          retry_inc, entering, wrap, err_hit;

  occ_gtp_sync_bit u_sync_lock (.clk_i(init_clk_i), .rst_i(init_rst_i), .d_i(pll_lock_i),    .q_o(lock_s));
  occ_gtp_sync_bit u_sync_txd  (.clk_i(init_clk_i), .rst_i(init_rst_i), .d_i(txresetdone_i), .q_o(txdone_s));
  occ_gtp_sync_bit u_sync_rxd  (.clk_i(init_clk_i), .rst_i(init_rst_i), .d_i(rxresetdone_i), .q_o(rxdone_s));
  occ_gtp_sync_bit u_sync_aln  (.clk_i(init_clk_i), .rst_i(init_rst_i), .d_i(rx_aligned_i),  .q_o(aligned_s));

  // The pulse that brings the window count to g_ERR_MAX trips immediately,
  // so a threshold hit on the wrap cycle is not lost to the window clear.
  assign err_hit = link_err_i && (err_cnt_q >= C_ERR_LAST);
  assign wrap    = (state_q == ST_LINK_UP) && (timer_q == C_WIN_LAST);

  // Next-state selection: disable, then lock loss, then errors, then progress/timeout.
  always_comb begin
    state_d   = state_q;
    retry_inc = 1'b0;
    if (!enable_i) begin
      state_d = ST_IDLE;
    end else if (!lock_s && (state_q inside {ST_GT_RST, ST_GT_WAIT, ST_ALIGN, ST_LINK_UP})) begin
      state_d   = ST_PLL_RST;
      retry_inc = 1'b1;
    end else begin
      case (state_q)
        ST_IDLE:     state_d = ST_PLL_RST;
        ST_PLL_RST:  if (timer_q == C_PLL_LAST) state_d = ST_PLL_WAIT;
        ST_PLL_WAIT: begin
          if (lock_s && (lock_cnt_q == C_LOCK_LAST)) begin
            state_d = ST_GT_RST;
          end else if (timer_q == C_TO_LAST) begin
            state_d   = ST_PLL_RST;
            retry_inc = 1'b1;
          end
        end
        ST_GT_RST:   if (timer_q == C_GT_LAST) state_d = ST_GT_WAIT;
        ST_GT_WAIT: begin
          if (txdone_s && rxdone_s) begin
            state_d = ST_ALIGN;
          end else if (timer_q == C_TO_LAST) begin
            state_d   = ST_GT_RST;
            retry_inc = 1'b1;
          end
        end
        ST_ALIGN: begin
          if (aligned_s) begin
            state_d = ST_LINK_UP;
          end else if (timer_q == C_TO_LAST) begin
            state_d   = ST_GT_RST;
            retry_inc = 1'b1;
          end
        end
        ST_LINK_UP: begin
          if (err_hit) begin
            state_d   = ST_GT_RST;
            retry_inc = 1'b1;
          end else if (!aligned_s) begin
            state_d = ST_ALIGN;
          end
        end
        default:     state_d = ST_IDLE;
      endcase
    end
  end

  // Shared timer, lock-stability, error-window and retry counters.
  always_comb begin
    entering = (state_d != state_q);

    timer_d = timer_q + TW'(1);
    if (entering || (state_q == ST_IDLE) || wrap) timer_d = '0;

    lock_cnt_d = '0;
    if (!entering && (state_q == ST_PLL_WAIT) && lock_s) lock_cnt_d = lock_cnt_q + LW'(1);

    err_cnt_d = err_cnt_q;
    if (entering || (state_q != ST_LINK_UP) || wrap) begin
      err_cnt_d = '0;
    end else if (link_err_i && (err_cnt_q != C_ERR_SAT)) begin
      err_cnt_d = err_cnt_q + EW'(1);
    end

    retry_d = retry_q;
    if (retry_inc && (retry_q != 8'hFF)) retry_d = retry_q + 8'd1;
  end

  // Tile control levels decoded from the state being entered, so they register with it.
  always_comb begin
    pll_rst_d = (state_d == ST_IDLE) || (state_d == ST_PLL_RST);
    gt_rst_d  = state_d inside {ST_IDLE, ST_PLL_RST, ST_PLL_WAIT, ST_GT_RST};
    userrdy_d = state_d inside {ST_GT_RST, ST_GT_WAIT, ST_ALIGN, ST_LINK_UP};
    comma_d   = (state_d == ST_ALIGN) || (state_d == ST_LINK_UP);
    link_up_d = (state_d == ST_LINK_UP);
  end

  // State, counters and registered outputs.
  always_ff @(posedge init_clk_i) begin
    if (init_rst_i) begin
      state_q    <= ST_IDLE;
      timer_q    <= '0;
      lock_cnt_q <= '0;
      err_cnt_q  <= '0;
      retry_q    <= '0;
      pll_rst_q  <= 1'b1;
      gt_rst_q   <= 1'b1;
      userrdy_q  <= 1'b0;
      comma_q    <= 1'b0;
      link_up_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      lock_cnt_q <= lock_cnt_d;
      err_cnt_q  <= err_cnt_d;
      retry_q    <= retry_d;
      pll_rst_q  <= pll_rst_d;
      gt_rst_q   <= gt_rst_d;
      userrdy_q  <= userrdy_d;
      comma_q    <= comma_d;
      link_up_q  <= link_up_d;
    end
  end

  assign pll_rst_o        = pll_rst_q;
  assign txreset_o        = gt_rst_q;
  assign rxreset_o        = gt_rst_q;
  assign txuserrdy_o      = userrdy_q;
  assign rxuserrdy_o      = userrdy_q;
  assign rxencommaalign_o = comma_q;
  assign link_up_o        = link_up_q;
  assign state_o          = state_q;
  assign retry_cnt_o      = retry_q;

endmodule

// File: tb/tb_occ_gtp_link_ctrl.sv
// Directed-sequence bench for occ_gtp_link_ctrl with randomized delays and
// error-pulse placement; expected transition times come from timing rules.
`timescale 1ns/1ps
module tb_occ_gtp_link_ctrl;

  localparam int N    = 10;
  localparam int TO   = 100;
  localparam int WIN  = 50;
  localparam int EMAX = 3;
  localparam int SYNC_LAT    = 3;  // two synchroniser flops plus the state register
  localparam int LOCK_STABLE = 8;
  localparam int GT_RST_LEN  = 4;

  localparam logic [2:0] S_IDLE = 3'd0, S_PLL_RST = 3'd1, S_PLL_WAIT = 3'd2,
                         S_GT_RST = 3'd3, S_GT_WAIT = 3'd4, S_ALIGN = 3'd5, S_LINK_UP = 3'd6;

  logic       clk = 1'b0;
  logic       rst, en, lock, txd, rxd, al, lerr;
  logic       pll_rst, txr, rxr, txu, rxu, comma, lup;
  logic [2:0] st;
  logic [7:0] retry;

  int cyc = 0;
  int vectors = 0;
  int miscompares = 0;
  int pq[$];

  always #5 clk = ~clk;

  occ_gtp_link_ctrl #(
    .g_PLL_RST_CYCLES(N), .g_TIMEOUT(TO), .g_ERR_WINDOW(WIN), .g_ERR_MAX(EMAX)
  ) dut (
    .init_clk_i(clk), .init_rst_i(rst), .enable_i(en), .pll_lock_i(lock),
    .txresetdone_i(txd), .rxresetdone_i(rxd), .rx_aligned_i(al), .link_err_i(lerr),
    .pll_rst_o(pll_rst), .txreset_o(txr), .rxreset_o(rxr), .txuserrdy_o(txu),
    .rxuserrdy_o(rxu), .rxencommaalign_o(comma), .link_up_o(lup), .state_o(st),
    .retry_cnt_o(retry)
  );

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic run_to(input int c);
    while (cyc < c) tick();
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic wait_state(input string tag, input logic [2:0] s, input int exp_cyc);
    int n;
    n = 0;
    while (st !== s && n < 400) begin
      tick();
      n++;
    end
    chk({tag, "_state"}, 32'(st), 32'(s));
    chk({tag, "_cyc"}, cyc, exp_cyc);
  endtask

  task automatic pulse_at(input int c);
    run_to(c);
    lerr = 1'b1;
    tick();
    lerr = 1'b0;
  endtask

  function automatic int imax(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // Window-based error model: pulse driven at cycle c lands in window (c-up)/WIN
  // of the current LINK_UP visit; the EMAX-th pulse of a window trips next cycle.
  function automatic int trip_cycle(input int up);
    int cnt [8];
    int w;
    foreach (cnt[i]) cnt[i] = 0;
    for (int i = 0; i < pq.size(); i++) begin
      w = (pq[i] - up) / WIN;
      cnt[w]++;
      if (cnt[w] == EMAX) return pq[i] + 1;
    end
    return -1;
  endfunction

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int t, f, g, d, r, a, b, c, up, trip, p, exp_retry;
    rst = 1'b1; en = 1'b0; lock = 1'b0; txd = 1'b0; rxd = 1'b0; al = 1'b0; lerr = 1'b0;
    repeat (3) tick();

    // Reset values
    chk("rst_pll_rst", 32'(pll_rst), 1);
    chk("rst_txreset", 32'(txr), 1);
    chk("rst_rxreset", 32'(rxr), 1);
    chk("rst_txuserrdy", 32'(txu), 0);
    chk("rst_rxuserrdy", 32'(rxu), 0);
    chk("rst_comma", 32'(comma), 0);
    chk("rst_link_up", 32'(lup), 0);
    chk("rst_state", 32'(st), 32'(S_IDLE));
    chk("rst_retry", 32'(retry), 0);
    rst = 1'b0;
    tick();
    chk("idle_disabled", 32'(st), 32'(S_IDLE));

    // Nominal bring-up with randomized lock / resetdone / aligned timing
    t = cyc; en = 1'b1;
    wait_state("en_pll_rst", S_PLL_RST, t + 1);
    chk("pll_rst_high", 32'(pll_rst), 1);
    wait_state("pll_wait", S_PLL_WAIT, t + 1 + N);
    chk("pll_rst_fall", 32'(pll_rst), 0);
    f = cyc;
    d = int'($urandom_range(5, 40));
    run_to(f + d); lock = 1'b1; t = cyc;
    g = imax(f + 1, t + SYNC_LAT) + LOCK_STABLE - 1;
    wait_state("gt_rst", S_GT_RST, g);
    chk("gt_rst_txreset", 32'(txr), 1);
    chk("gt_rst_rxreset", 32'(rxr), 1);
    chk("gt_rst_txuserrdy", 32'(txu), 1);
    chk("gt_rst_rxuserrdy", 32'(rxu), 1);
    wait_state("gt_wait", S_GT_WAIT, g + GT_RST_LEN);
    chk("gt_wait_txreset", 32'(txr), 0);
    d = t + 30 + int'($urandom_range(0, 10));
    run_to(d); txd = 1'b1;
    r = int'($urandom_range(0, 5));
    run_to(d + r); rxd = 1'b1;
    wait_state("align", S_ALIGN, d + r + SYNC_LAT);
    chk("align_comma", 32'(comma), 1);
    chk("align_link_up", 32'(lup), 0);
    t = cyc + int'($urandom_range(5, 15));
    run_to(t); al = 1'b1;
    wait_state("link_up", S_LINK_UP, t + SYNC_LAT);
    chk("link_up_flag", 32'(lup), 1);
    chk("link_up_retry", 32'(retry), 0);

    // Error pulses: two per window for three windows, then three in one window
    up = cyc;
    pq.delete();
    for (int w = 0; w < 3; w++) begin
      a = int'($urandom_range(0, 48));
      b = int'($urandom_range(a + 1, 49));
      pq.push_back(up + w * WIN + a);
      pq.push_back(up + w * WIN + b);
    end
    a = int'($urandom_range(0, 47));
    b = int'($urandom_range(a + 1, 48));
    c = int'($urandom_range(b + 1, 49));
    pq.push_back(up + 3 * WIN + a);
    pq.push_back(up + 3 * WIN + b);
    pq.push_back(up + 3 * WIN + c);
    trip = trip_cycle(up);
    for (int i = 0; i < 6; i++) pulse_at(pq[i]);
    run_to(up + 3 * WIN);
    chk("err_two_per_win_state", 32'(st), 32'(S_LINK_UP));
    chk("err_two_per_win_retry", 32'(retry), 0);
    for (int i = 6; i < 9; i++) pulse_at(pq[i]);
    wait_state("err_burst", S_GT_RST, trip);
    chk("err_burst_txreset", 32'(txr), 1);
    chk("err_burst_rxreset", 32'(rxr), 1);
    chk("err_burst_retry", 32'(retry), 1);
    wait_state("err_burst_gt_wait", S_GT_WAIT, trip + GT_RST_LEN);
    chk("err_burst_txreset_low", 32'(txr), 0);
    wait_state("err_burst_align", S_ALIGN, trip + GT_RST_LEN + 1);
    wait_state("err_burst_up", S_LINK_UP, trip + GT_RST_LEN + 2);

    // Threshold reached on the window wrap cycle
    up = cyc;
    pq.delete();
    a = int'($urandom_range(0, 47));
    b = int'($urandom_range(a + 1, 48));
    pq.push_back(up + a);
    pq.push_back(up + b);
    pq.push_back(up + WIN - 1);
    trip = trip_cycle(up);
    for (int i = 0; i < 3; i++) pulse_at(pq[i]);
    wait_state("wrap_hit", S_GT_RST, trip);
    chk("wrap_hit_retry", 32'(retry), 2);
    wait_state("wrap_hit_up", S_LINK_UP, trip + GT_RST_LEN + 2);

    // Pulses straddling a wrap are counted in separate windows
    up = cyc;
    pq.delete();
    pq.push_back(up + WIN - 2);
    pq.push_back(up + WIN - 1);
    pq.push_back(up + WIN);
    for (int i = 0; i < 3; i++) pulse_at(pq[i]);
    run_to(up + WIN + 10);
    chk("wrap_clear_state", 32'(st), 32'(S_LINK_UP));
    chk("wrap_clear_retry", 32'(retry), 2);

    // Alignment loss and recovery
    t = cyc; al = 1'b0;
    wait_state("align_loss", S_ALIGN, t + SYNC_LAT);
    chk("align_loss_link_up", 32'(lup), 0);
    chk("align_loss_retry", 32'(retry), 2);
    chk("align_loss_comma", 32'(comma), 1);
    t = cyc + int'($urandom_range(5, 30));
    run_to(t); al = 1'b1;
    wait_state("realign", S_LINK_UP, t + SYNC_LAT);
    chk("realign_retry", 32'(retry), 2);

    // Lock loss, then repeated lock timeouts until the retry counter saturates
    t = cyc; lock = 1'b0;
    wait_state("lock_loss", S_PLL_RST, t + SYNC_LAT);
    chk("lock_loss_retry", 32'(retry), 3);
    chk("lock_loss_pll_rst", 32'(pll_rst), 1);
    exp_retry = 3;
    p = cyc;
    for (int k = 0; k < 256; k++) begin
      wait_state("to_pll_wait", S_PLL_WAIT, p + N);
      wait_state("to_pll_rst", S_PLL_RST, p + N + TO);
      exp_retry = (exp_retry < 255) ? exp_retry + 1 : 255;
      chk("timeout_retry", 32'(retry), exp_retry);
      p = cyc;
    end

    // Relock, then disable while waiting for PCS reset done
    lock = 1'b1; txd = 1'b0; rxd = 1'b0; t = cyc;
    g = imax(p + N + 1, t + SYNC_LAT) + LOCK_STABLE - 1;
    wait_state("relock_gt_rst", S_GT_RST, g);
    wait_state("relock_gt_wait", S_GT_WAIT, g + GT_RST_LEN);
    run_to(cyc + int'($urandom_range(0, 20)));
    t = cyc; en = 1'b0;
    wait_state("disable", S_IDLE, t + 1);
    chk("disable_pll_rst", 32'(pll_rst), 1);
    chk("disable_txreset", 32'(txr), 1);
    chk("disable_rxreset", 32'(rxr), 1);
    chk("disable_userrdy", 32'(txu), 0);
    chk("disable_retry", 32'(retry), 255);

    // Re-enable with everything already settled
    t = cyc; en = 1'b1;
    wait_state("reen_pll_rst", S_PLL_RST, t + 1);
    wait_state("reen_pll_wait", S_PLL_WAIT, t + 1 + N);
    f = cyc;
    wait_state("reen_gt_rst", S_GT_RST, f + LOCK_STABLE);
    d = cyc + GT_RST_LEN + int'($urandom_range(0, 20));
    run_to(d); txd = 1'b1; rxd = 1'b1;
    wait_state("reen_align", S_ALIGN, d + SYNC_LAT);
    wait_state("reen_up", S_LINK_UP, d + SYNC_LAT + 1);
    chk("reen_retry", 32'(retry), 255);

    // Synchronous reset while the link is up
    rst = 1'b1;
    tick();
    chk("midrst_state", 32'(st), 32'(S_IDLE));
    chk("midrst_retry", 32'(retry), 0);
    chk("midrst_pll_rst", 32'(pll_rst), 1);
    chk("midrst_txreset", 32'(txr), 1);
    chk("midrst_userrdy", 32'(rxu), 0);
    chk("midrst_comma", 32'(comma), 0);
    chk("midrst_link_up", 32'(lup), 0);
    rst = 1'b0; t = cyc;
    wait_state("postrst_pll_rst", S_PLL_RST, t + 1);
    wait_state("postrst_pll_wait", S_PLL_WAIT, t + 1 + N);
    f = cyc;
    wait_state("postrst_gt_rst", S_GT_RST, imax(f + 1, t + SYNC_LAT) + LOCK_STABLE - 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
